// File: rtl/riscv_v_alu_wb_buffer.sv
// Elastic writeback buffer between the vector ALU and the VRF write port.
// Holds result beats with per-byte flags in a small FIFO and produces a
// one-cycle per-instruction summary of sticky OF/CF as beats are retired.
module riscv_v_alu_wb_buffer #(
    parameter  int unsigned DATA_WIDTH = 128,
    parameter  int unsigned DEPTH      = 2,
    parameter  int unsigned ADDR_W     = 5,
    localparam int unsigned NUM_BYTES  = DATA_WIDTH / 8,
    localparam int unsigned PTR_W      = $clog2(DEPTH),
    localparam int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [NUM_BYTES-1:0]  in_zf,
    input  logic [NUM_BYTES-1:0]  in_of,
    input  logic [NUM_BYTES-1:0]  in_cf,
    input  logic [ADDR_W-1:0]     in_vd,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_BYTES-1:0]  out_zf,
    output logic [NUM_BYTES-1:0]  out_of,
    output logic [NUM_BYTES-1:0]  out_cf,
    output logic [ADDR_W-1:0]     out_vd,
    output logic                  out_last,
    output logic                  sum_valid,
    output logic                  sum_of,
    output logic                  sum_cf,
    output logic [CNT_W-1:0]      count
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [NUM_BYTES-1:0]  zf;
        logic [NUM_BYTES-1:0]  ovf;
        logic [NUM_BYTES-1:0]  cf;
        logic [ADDR_W-1:0]     vd;
        logic                  last;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           wr_entry;
    entry_t           head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             acc_of_q, acc_of_d;
    logic             acc_cf_q, acc_cf_d;
    logic             sum_valid_q, sum_valid_d;
    logic             sum_of_q, sum_of_d;
    logic             sum_cf_q, sum_cf_d;
    logic             acc_of_n, acc_cf_n;
    logic             push, pop;

    // Head entry and handshake qualification; flush suppresses both transfers.
    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q < CNT_W'(DEPTH)) | out_ready;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign wr_entry = '{data: in_data, zf: in_zf, ovf: in_of, cf: in_cf,
                        vd: in_vd, last: in_last};

    assign out_data  = head.data;
    assign out_zf    = head.zf;
    assign out_of    = head.ovf;
    assign out_cf    = head.cf;
    assign out_vd    = head.vd;
    assign out_last  = head.last;
    assign sum_valid = sum_valid_q;
    assign sum_of    = sum_of_q;
    assign sum_cf    = sum_cf_q;
    assign count     = count_q;

    // Entry storage: written on push only, intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Next-state: pointers, occupancy, sticky flag accumulation and summary.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        acc_of_d    = acc_of_q;
        acc_cf_d    = acc_cf_q;
        sum_valid_d = 1'b0;
        sum_of_d    = sum_of_q;
        sum_cf_d    = sum_cf_q;
        acc_of_n    = acc_of_q | (|head.ovf);
        acc_cf_n    = acc_cf_q | (|head.cf);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            acc_of_d = 1'b0;
            acc_cf_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (pop) begin
                if (head.last) begin
                    sum_valid_d = 1'b1;
                    sum_of_d    = acc_of_n;
                    sum_cf_d    = acc_cf_n;
                    acc_of_d    = 1'b0;
                    acc_cf_d    = 1'b0;
                end else begin
                    acc_of_d    = acc_of_n;
                    acc_cf_d    = acc_cf_n;
                end
            end
        end
    end

    // Control and summary state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            acc_of_q    <= 1'b0;
            acc_cf_q    <= 1'b0;
            sum_valid_q <= 1'b0;
            sum_of_q    <= 1'b0;
            sum_cf_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            acc_of_q    <= acc_of_d;
            acc_cf_q    <= acc_cf_d;
            sum_valid_q <= sum_valid_d;
            sum_of_q    <= sum_of_d;
            sum_cf_q    <= sum_cf_d;
        end
    end

endmodule
